// File: rtl/slant_lane_rx_if.sv
// rtl/slant_lane_rx_if.sv - pair output bus of one slant-link lane receiver
interface slant_lane_rx_if;
    logic        Out_valid;
    logic [4:0]  Out_Y;
    logic [4:0]  Out_C;
    logic [15:0] Out_addr;
    logic        Out_sof;
    logic        Out_field;

    modport master (output Out_valid, Out_Y, Out_C, Out_addr, Out_sof, Out_field);
    modport slave  (input  Out_valid, Out_Y, Out_C, Out_addr, Out_sof, Out_field);
endinterface

// File: rtl/slant_lane_rx.sv
// rtl/slant_lane_rx.sv - slant-link lane receiver: symbol recovery, sync detect, Y/C unpack
// Optional SLANT_RX_STATS_EN adds Frame_cnt/Err_cnt statistics outputs.
module slant_lane_rx #(
    parameter int          SYM_CLKS   = 25,
    parameter int          LINE_SYMS  = 80,
    parameter int          FRAME_SYMS = 76800,
    parameter logic [23:0] FRAME1     = 24'haab155,
    parameter logic [23:0] FRAME0     = 24'haa8d55,
    parameter logic [15:0] HSYNC      = 16'ha355
) (
    input  logic            Cclk,
    input  logic            rstn,
    input  logic [7:0]      RxData,
    slant_lane_rx_if.master out,
    output logic            Sync_err,
    output logic            Locked
`ifdef SLANT_RX_STATS_EN
    ,
    output logic [15:0]     Frame_cnt,
    output logic [15:0]     Err_cnt
`endif
);
    localparam int CW = $clog2(SYM_CLKS);
    localparam int LW = $clog2(LINE_SYMS + 1);
    localparam logic [CW-1:0] SYM_LAST  = CW'(SYM_CLKS - 1);
    localparam logic [CW-1:0] SYM_MID   = CW'(SYM_CLKS / 2);
    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_SYMS - 1);
    localparam logic [15:0]   PAIR_LAST = 16'(FRAME_SYMS / 2 - 1);

    typedef enum logic [1:0] {HUNT, DATA, LSYNC} state_t;

    state_t        state, state_d;
    logic [7:0]    rx_q;
    logic [CW-1:0] sym_cnt;
    logic          sym_stb, is_mark, mark_bit, is_data;
    logic [4:0]    data_v;
    logic [23:0]   hunt_sh, sh_d, sh_shift;
    logic [4:0]    y_hold, y_d;
    logic [LW-1:0] line_cnt, line_d;
    logic [15:0]   pair_cnt, pair_d;
    logic [3:0]    hs_idx, hs_d;
    logic          valid_q, valid_d, sof_q, sof_d, field_q, field_d, err_q, err_d;
    logic [4:0]    oy_q, oy_d, oc_q, oc_d;
    logic [15:0]   addr_q, addr_d;

    // A byte change re-aligns the symbol phase; a held byte repeats once per SYM_CLKS.
    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            rx_q    <= 8'h00;
            sym_cnt <= '0;
        end else begin
            rx_q <= RxData;
            if (RxData != rx_q || sym_cnt == SYM_LAST)
                sym_cnt <= '0;
            else
                sym_cnt <= sym_cnt + 1'b1;
        end
    end

    assign sym_stb  = (sym_cnt == SYM_MID);
    assign is_mark  = (rx_q == 8'hff) || (rx_q == 8'h01);
    assign mark_bit = rx_q[1];
    assign is_data  = !rx_q[7] && (rx_q[1:0] == 2'b00);
    assign data_v   = rx_q[6:2];

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            state    <= HUNT;
            hunt_sh  <= '0;
            y_hold   <= '0;
            line_cnt <= '0;
            pair_cnt <= '0;
            hs_idx   <= '0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            field_q  <= 1'b0;
            err_q    <= 1'b0;
            oy_q     <= '0;
            oc_q     <= '0;
            addr_q   <= '0;
        end else begin
            state    <= state_d;
            hunt_sh  <= sh_d;
            y_hold   <= y_d;
            line_cnt <= line_d;
            pair_cnt <= pair_d;
            hs_idx   <= hs_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            field_q  <= field_d;
            err_q    <= err_d;
            oy_q     <= oy_d;
            oc_q     <= oc_d;
            addr_q   <= addr_d;
        end
    end

    always_comb begin
        state_d  = state;
        sh_d     = hunt_sh;
        y_d      = y_hold;
        line_d   = line_cnt;
        pair_d   = pair_cnt;
        hs_d     = hs_idx;
        field_d  = field_q;
        valid_d  = 1'b0;
        sof_d    = 1'b0;
        err_d    = 1'b0;
        oy_d     = oy_q;
        oc_d     = oc_q;
        addr_d   = addr_q;
        sh_shift = {hunt_sh[22:0], mark_bit};
        if (sym_stb) begin
            case (state)
                HUNT: begin
                    if (!is_mark) begin
                        sh_d = '0;
                    end else if (sh_shift == FRAME1 || sh_shift == FRAME0) begin
                        field_d  = (sh_shift == FRAME1);
                        state_d  = DATA;
                        sh_d     = '0;
                        line_d   = '0;
                        pair_d   = '0;
                    end else begin
                        sh_d = sh_shift;
                    end
                end
                DATA: begin
                    if (!is_data) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else begin
                        line_d = line_cnt + 1'b1;
                        if (!line_cnt[0]) begin
                            y_d = data_v;
                        end else begin
                            valid_d = 1'b1;
                            oy_d    = y_hold;
                            oc_d    = data_v;
                            addr_d  = pair_cnt;
                            sof_d   = (pair_cnt == 16'd0);
                            pair_d  = pair_cnt + 16'd1;
                            // The last line of a frame has no trailing line marker.
                            if (pair_cnt == PAIR_LAST) begin
                                state_d = HUNT;
                            end else if (line_cnt == LINE_LAST) begin
                                state_d = LSYNC;
                                hs_d    = 4'd15;
                            end
                        end
                    end
                end
                LSYNC: begin
                    if (is_mark && mark_bit == HSYNC[hs_idx]) begin
                        hs_d = hs_idx - 4'd1;
                        if (hs_idx == 4'd0) begin
                            state_d = DATA;
                            line_d  = '0;
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    assign out.Out_valid = valid_q;
    assign out.Out_Y     = oy_q;
    assign out.Out_C     = oc_q;
    assign out.Out_addr  = addr_q;
    assign out.Out_sof   = sof_q;
    assign out.Out_field = field_q;
    assign Sync_err      = err_q;
    assign Locked        = (state == DATA) || (state == LSYNC);

`ifdef SLANT_RX_STATS_EN
    logic frame_done;
    assign frame_done = sym_stb && state == DATA && is_data && line_cnt[0] && pair_cnt == PAIR_LAST;

    always_ff @(posedge Cclk or negedge rstn) begin
        if (!rstn) begin
            Frame_cnt <= 16'h0000;
            Err_cnt   <= 16'h0000;
        end else begin
            if (frame_done)
                Frame_cnt <= Frame_cnt + 16'd1;
            if (err_d && Err_cnt != 16'hffff)
                Err_cnt <= Err_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_slant_lane_rx.sv
// tb/tb_slant_lane_rx.sv - self-checking bench for slant_lane_rx (reduced frame geometry)
module tb_slant_lane_rx;
    localparam int SC = 6;
    localparam int LS = 8;
    localparam int FS = 64;
    localparam logic [23:0] F1 = 24'haab155;
    localparam logic [23:0] F0 = 24'haa8d55;
    localparam logic [15:0] HS = 16'ha355;

    logic       Cclk = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] RxData = 8'h02;
    logic       Sync_err, Locked;
    slant_lane_rx_if bus ();
`ifdef SLANT_RX_STATS_EN
    logic [15:0] Frame_cnt, Err_cnt;
`endif

    slant_lane_rx #(.SYM_CLKS(SC), .LINE_SYMS(LS), .FRAME_SYMS(FS)) dut (
        .Cclk(Cclk), .rstn(rstn), .RxData(RxData), .out(bus),
        .Sync_err(Sync_err), .Locked(Locked)
`ifdef SLANT_RX_STATS_EN
        , .Frame_cnt(Frame_cnt), .Err_cnt(Err_cnt)
`endif
    );

    always #5 Cclk = ~Cclk;

    typedef struct packed {
        logic [4:0]  y;
        logic [4:0]  c;
        logic [15:0] addr;
        logic        sof;
        logic        field;
    } pair_t;

    typedef struct {
        logic [7:0]  sym;
        int          npairs;
        logic [4:0]  y;
        logic [4:0]  c;
        logic [15:0] addr;
        logic        sof;
        int          nerr;
        logic        locked;
    } vec_t;

    int    npass = 0, ntotal = 0;
    pair_t got_q[$], exp_q[$];
    int    err_pulses = 0, exp_err = 0;
    time   last_valid_t = 0, sym_t = 0;

    // Reference: symbol-level view of the protocol
    logic        m_locked, m_field;
    logic [23:0] m_hist;
    int          m_nsyms, m_hs;
    logic [4:0]  m_y;

    task automatic check(input string name, input longint act, input longint exp);
        ntotal++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        m_locked = 1'b0; m_field = 1'b0; m_hist = '0; m_nsyms = 0; m_hs = 16; m_y = '0;
    endfunction

    function automatic void model_sym(input logic [7:0] b);
        bit    mark = (b == 8'hff) || (b == 8'h01);
        bit    dat  = !b[7] && (b[1:0] == 2'b00);
        pair_t p;
        if (!m_locked) begin
            if (!mark) m_hist = '0;
            else begin
                m_hist = {m_hist[22:0], b == 8'hff};
                if (m_hist == F1 || m_hist == F0) begin
                    m_locked = 1'b1; m_field = (m_hist == F1);
                    m_nsyms = 0; m_hs = 16; m_hist = '0;
                end
            end
        end else if (m_nsyms > 0 && m_nsyms % LS == 0 && m_hs < 16) begin
            if (mark && (b == 8'hff) == HS[15-m_hs]) m_hs++;
            else begin exp_err++; m_locked = 1'b0; m_hist = '0; end
        end else if (dat) begin
            if (m_nsyms % 2 == 0) m_y = b[6:2];
            else begin
                p.y = m_y; p.c = b[6:2]; p.addr = 16'(m_nsyms / 2);
                p.sof = (m_nsyms / 2 == 0); p.field = m_field;
                exp_q.push_back(p);
            end
            m_nsyms++;
            if (m_nsyms == FS) m_locked = 1'b0;
            else if (m_nsyms % LS == 0) m_hs = 0;
        end else begin
            exp_err++; m_locked = 1'b0; m_hist = '0;
        end
    endfunction

    always @(negedge Cclk) begin
        if (bus.Out_valid) begin
            pair_t p;
            p.y = bus.Out_Y; p.c = bus.Out_C; p.addr = bus.Out_addr;
            p.sof = bus.Out_sof; p.field = bus.Out_field;
            got_q.push_back(p);
            last_valid_t = $time;
        end
        if (Sync_err) err_pulses++;
    end

    task automatic send_sym(input logic [7:0] b);
        RxData = b;
        sym_t = $time;
        model_sym(b);
        repeat (SC) @(negedge Cclk);
    endtask

    task automatic send_marker(input logic [23:0] mk);
        for (int i = 23; i >= 0; i--) send_sym(mk[i] ? 8'hff : 8'h01);
    endtask

    task automatic emit(input logic [7:0] b, inout int ord, input int bad_at);
        logic [7:0] subs [5];
        logic [7:0] s;
        subs[0] = 8'h03; subs[1] = 8'h80; subs[2] = 8'hff; subs[3] = 8'h01; subs[4] = 8'h55;
        s = b;
        if (ord == bad_at) s = subs[$urandom_range(0, 4)];
        ord++;
        send_sym(s);
    endtask

    task automatic send_frame(input logic [23:0] mk, input int bad_at);
        int ord = 0;
        for (int i = 23; i >= 0; i--) emit(mk[i] ? 8'hff : 8'h01, ord, bad_at);
        for (int k = 0; k < FS; k++) begin
            if (k > 0 && k % LS == 0)
                for (int i = 15; i >= 0; i--) emit(HS[i] ? 8'hff : 8'h01, ord, bad_at);
            emit({1'b0, 5'($urandom), 2'b00}, ord, bad_at);
        end
    endtask

    task automatic clear_all();
        got_q.delete(); exp_q.delete(); err_pulses = 0; exp_err = 0;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " pair count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s pair %0d", tag, i), got_q[i], exp_q[i]);
        check({tag, " sync errors"}, err_pulses, exp_err);
        clear_all();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        vec_t v;
        int   n_before;

        // Odd-field marker, two pairs, then an illegal byte
        for (int i = 23; i >= 0; i--) begin
            v = '{F1[i] ? 8'hff : 8'h01, 0, 5'd0, 5'd0, 16'd0, 1'b0, 0, i == 0};
            tbl.push_back(v);
        end
        tbl.push_back('{8'h04, 0, 5'd0,  5'd0, 16'd0, 1'b0, 0, 1'b1});
        tbl.push_back('{8'h08, 1, 5'd1,  5'd2, 16'd0, 1'b1, 0, 1'b1});
        tbl.push_back('{8'h7c, 0, 5'd0,  5'd0, 16'd0, 1'b0, 0, 1'b1});
        tbl.push_back('{8'h00, 1, 5'd31, 5'd0, 16'd1, 1'b0, 0, 1'b1});
        tbl.push_back('{8'h03, 0, 5'd0,  5'd0, 16'd0, 1'b0, 1, 1'b0});

        model_reset();
        repeat (3) @(negedge Cclk);
        check("reset Out_valid", bus.Out_valid, 0);
        check("reset Out_Y", bus.Out_Y, 0);
        check("reset Out_C", bus.Out_C, 0);
        check("reset Out_addr", bus.Out_addr, 0);
        check("reset Out_sof", bus.Out_sof, 0);
        check("reset Out_field", bus.Out_field, 0);
        check("reset Sync_err", Sync_err, 0);
        check("reset Locked", Locked, 0);
        rstn = 1'b1;
        send_sym(8'h02);
        send_sym(8'h02);
        clear_all();

        foreach (tbl[i]) begin
            got_q.delete(); err_pulses = 0;
            send_sym(tbl[i].sym);
            check($sformatf("tbl %0d pairs", i), got_q.size(), tbl[i].npairs);
            if (tbl[i].npairs > 0 && got_q.size() > 0) begin
                check($sformatf("tbl %0d Y", i), got_q[0].y, tbl[i].y);
                check($sformatf("tbl %0d C", i), got_q[0].c, tbl[i].c);
                check($sformatf("tbl %0d addr", i), got_q[0].addr, tbl[i].addr);
                check($sformatf("tbl %0d sof", i), got_q[0].sof, tbl[i].sof);
                check($sformatf("tbl %0d latency", i), last_valid_t - sym_t, (SC / 2 + 2) * 10);
            end
            check($sformatf("tbl %0d Sync_err", i), err_pulses, tbl[i].nerr);
            check($sformatf("tbl %0d Locked", i), Locked, tbl[i].locked);
        end
        check("odd field", bus.Out_field, 1);
`ifdef SLANT_RX_STATS_EN
        check("Err_cnt after illegal byte", Err_cnt, 1);
`endif
        clear_all();

        // Complete even-field frame
        send_frame(F0, -1);
        check("frame pair total", got_q.size(), FS / 2);
        if (got_q.size() > 0) begin
            check("frame first sof", got_q[0].sof, 1);
            check("frame last addr", got_q[got_q.size()-1].addr, FS / 2 - 1);
        end
        check("frame end Locked", Locked, 0);
        check("even field", bus.Out_field, 0);
`ifdef SLANT_RX_STATS_EN
        check("Frame_cnt after frame", Frame_cnt, 1);
`endif
        compare_model("full frame");
        send_sym(8'h02);
        clear_all();

        // Line marker with bit 5 flipped
        send_marker(F1);
        for (int k = 0; k < LS; k++) send_sym({1'b0, 5'(k), 2'b00});
        for (int i = 15; i >= 0; i--) send_sym((HS[i] ^ (i == 5)) ? 8'hff : 8'h01);
        check("hsync flip Locked", Locked, 0);
        n_before = got_q.size();
        for (int k = 0; k < 6; k++) send_sym({1'b0, 5'(k + 3), 2'b00});
        check("hsync flip no pairs after", got_q.size() - n_before, 0);
        check("hsync flip pulses", err_pulses, 1);
        compare_model("hsync flip");

        // Held data byte repeats by symbol-time wrap
        send_marker(F1);
        for (int k = 0; k < 6; k++) send_sym(8'h10);
        check("repeat pairs", got_q.size(), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) begin
            check($sformatf("repeat %0d Y", i), got_q[i].y, 4);
            check($sformatf("repeat %0d C", i), got_q[i].c, 4);
        end
        send_sym(8'h03);
        compare_model("repeat");

        // Reset asserted in the middle of a line
        send_marker(F1);
        for (int k = 0; k < 5; k++) send_sym({1'b0, 5'(k + 9), 2'b00});
        RxData = 8'h08;
        repeat (2) @(negedge Cclk);
        rstn = 1'b0;
        #1;
        check("midreset Out_addr", bus.Out_addr, 0);
        check("midreset Out_Y", bus.Out_Y, 0);
        check("midreset Out_field", bus.Out_field, 0);
        check("midreset Locked", Locked, 0);
        @(negedge Cclk);
        rstn = 1'b1;
        model_reset();
        clear_all();
        send_sym(8'h02);
        send_marker(F1);
        for (int k = 0; k < 4; k++) send_sym({1'b0, 5'(k + 20), 2'b00});
        if (got_q.size() > 0) check("relock first addr", got_q[0].addr, 0);
        send_sym(8'h03);
        compare_model("relock");

        // Randomized frames, some with one corrupted symbol
        for (int r = 0; r < 8; r++) begin
            int bad_at;
            bad_at = ($urandom_range(0, 2) != 0) ? int'($urandom_range(0, 24 + FS + (FS / LS - 1) * 16 - 1)) : -1;
            send_frame(($urandom_range(0, 1) != 0) ? F1 : F0, bad_at);
            send_sym(8'h02);
            send_sym(8'h02);
            compare_model($sformatf("random frame %0d", r));
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
